// File: rtl/ring_counter_mon_pkg.sv
// Shared constants and helpers for the one-hot ring counter and its monitors.
package ring_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic onehot_chk(input logic [63:0] vec);
        return ($countones(vec) == 1);
    endfunction

endpackage

// File: rtl/ring_counter_mon_onehot_rotate.sv
// Combinational rotate of a one-hot vector by a fixed stride, up (toward MSB) or down.
module onehot_rotate
    import ring_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] vec,
    input  logic             dir,
    output logic [WIDTH-1:0] rot
);

    always_comb begin
        if (dir == DIR_UP) begin
            rot = (vec << STEP) | (vec >> (WIDTH - STEP));
        end else begin
            rot = (vec >> STEP) | (vec << (WIDTH - STEP));
        end
    end

endmodule

// File: rtl/ring_counter_mon.sv
// One-hot ring counter with stride, direction, load, saturating wrap count
// and sticky safety monitor.
module ring_counter_mon
    import ring_pkg::*;
#(
    parameter int  WIDTH    = 3,
    parameter int  INIT_POS = 1,
    parameter int  STEP     = 1,
    parameter int  WRAP_W   = 4,
    localparam int PW       = clog2_min1(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              dir,
    input  logic              load,
    input  logic [PW-1:0]     load_pos,
    output logic [WIDTH-1:0]  state,
    output logic [PW-1:0]     pos,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              z1,
    output logic              err
);

    localparam logic [PW:0] W_EXT = (PW+1)'(WIDTH);
    localparam logic [PW:0] S_EXT = (PW+1)'(STEP);

    logic [PW:0]      pos_ext;
    logic [PW:0]      up_sum;
    logic [PW:0]      nxt_pos;
    logic             nxt_wrap;
    logic             load_ok;
    logic [WIDTH-1:0] rot;

    onehot_rotate #(.WIDTH(WIDTH), .STEP(STEP)) u_rot (
        .vec (state),
        .dir (dir),
        .rot (rot)
    );

    assign pos_ext = {1'b0, pos};
    assign up_sum  = pos_ext + S_EXT;
    assign load_ok = ({1'b0, load_pos} < W_EXT);
    assign z1      = &state;

    // Modular step done as compare plus one correction, one extra bit of headroom.
    always_comb begin
        nxt_pos  = pos_ext;
        nxt_wrap = 1'b0;
        if (dir == DIR_UP) begin
            if (up_sum >= W_EXT) begin
                nxt_pos  = up_sum - W_EXT;
                nxt_wrap = 1'b1;
            end else begin
                nxt_pos = up_sum;
            end
        end else begin
            if (pos_ext < S_EXT) begin
                nxt_pos  = pos_ext + W_EXT - S_EXT;
                nxt_wrap = 1'b1;
            end else begin
                nxt_pos = pos_ext - S_EXT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= WIDTH'(1) << INIT_POS;
            pos      <= PW'(INIT_POS);
            wrap     <= 1'b0;
            wrap_cnt <= '0;
            err      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (!onehot_chk(64'(state))) begin
                err <= 1'b1;
            end
            if (load) begin
                if (load_ok) begin
                    state <= WIDTH'(1) << load_pos;
                    pos   <= load_pos;
                end else begin
                    err <= 1'b1;
                end
            end else if (en) begin
                state <= rot;
                pos   <= nxt_pos[PW-1:0];
                wrap  <= nxt_wrap;
                if (nxt_wrap && (wrap_cnt != '1)) begin
                    wrap_cnt <= wrap_cnt + WRAP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ring_counter_mon.sv
// Bench for ring_counter_mon: three parameterisations checked every cycle
// against an arithmetic position model plus hand-computed directed checkpoints.
module tb_ring_counter_mon;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance 0: W=3 S=1; instance 1: W=5 S=2; instance 2: W=2 S=1 WRAP_W=2.
    int W[3]    = '{3, 5, 2};
    int S[3]    = '{1, 2, 1};
    int CMAX[3] = '{15, 15, 3};

    logic [2:0] en, dir, load;
    logic [2:0] lp [3];

    logic [2:0] state_a;  logic [1:0] pos_a;  logic wrap_a;  logic [3:0] cnt_a;  logic z1_a;  logic err_a;
    logic [4:0] state_b;  logic [2:0] pos_b;  logic wrap_b;  logic [3:0] cnt_b;  logic z1_b;  logic err_b;
    logic [1:0] state_c;  logic [0:0] pos_c;  logic wrap_c;  logic [1:0] cnt_c;  logic z1_c;  logic err_c;

    ring_counter_mon #(.WIDTH(3), .INIT_POS(1), .STEP(1), .WRAP_W(4)) u_a (
        .clk(clk), .reset(reset), .en(en[0]), .dir(dir[0]), .load(load[0]),
        .load_pos(lp[0][1:0]), .state(state_a), .pos(pos_a), .wrap(wrap_a),
        .wrap_cnt(cnt_a), .z1(z1_a), .err(err_a)
    );
    ring_counter_mon #(.WIDTH(5), .INIT_POS(1), .STEP(2), .WRAP_W(4)) u_b (
        .clk(clk), .reset(reset), .en(en[1]), .dir(dir[1]), .load(load[1]),
        .load_pos(lp[1]), .state(state_b), .pos(pos_b), .wrap(wrap_b),
        .wrap_cnt(cnt_b), .z1(z1_b), .err(err_b)
    );
    ring_counter_mon #(.WIDTH(2), .INIT_POS(1), .STEP(1), .WRAP_W(2)) u_c (
        .clk(clk), .reset(reset), .en(en[2]), .dir(dir[2]), .load(load[2]),
        .load_pos(lp[2][0:0]), .state(state_c), .pos(pos_c), .wrap(wrap_c),
        .wrap_cnt(cnt_c), .z1(z1_c), .err(err_c)
    );

    logic [63:0] st[3], ps[3], cn[3];
    logic        wr[3], zz[3], er[3];
    assign st[0] = 64'(state_a); assign ps[0] = 64'(pos_a); assign cn[0] = 64'(cnt_a);
    assign st[1] = 64'(state_b); assign ps[1] = 64'(pos_b); assign cn[1] = 64'(cnt_b);
    assign st[2] = 64'(state_c); assign ps[2] = 64'(pos_c); assign cn[2] = 64'(cnt_c);
    assign wr[0] = wrap_a; assign zz[0] = z1_a; assign er[0] = err_a;
    assign wr[1] = wrap_b; assign zz[1] = z1_b; assign er[1] = err_b;
    assign wr[2] = wrap_c; assign zz[2] = z1_c; assign er[2] = err_c;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Position model: token index with plain modular arithmetic.
    int m_pos[3];
    bit m_wrap[3];
    int m_cnt[3];
    bit m_err[3];

    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                m_pos[k] = 1; m_wrap[k] = 1'b0; m_cnt[k] = 0; m_err[k] = 1'b0;
            end else if (load[k]) begin
                m_wrap[k] = 1'b0;
                if (int'(lp[k]) < W[k]) m_pos[k] = int'(lp[k]);
                else m_err[k] = 1'b1;
            end else if (en[k]) begin
                if (dir[k] == 1'b0) begin
                    m_wrap[k] = (m_pos[k] + S[k] >= W[k]);
                    m_pos[k]  = (m_pos[k] + S[k]) % W[k];
                end else begin
                    m_wrap[k] = (m_pos[k] < S[k]);
                    m_pos[k]  = (m_pos[k] - S[k] + W[k]) % W[k];
                end
                if (m_wrap[k] && m_cnt[k] < CMAX[k]) m_cnt[k]++;
            end else begin
                m_wrap[k] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("state%0d", k), st[k], 64'(1) << m_pos[k]);
                chk($sformatf("pos%0d", k), ps[k], 64'(m_pos[k]));
                chk($sformatf("wrap%0d", k), 64'(wr[k]), 64'(m_wrap[k]));
                chk($sformatf("wrap_cnt%0d", k), cn[k], 64'(m_cnt[k]));
                chk($sformatf("z1_%0d", k), 64'(zz[k]), 64'(0));
                chk($sformatf("err%0d", k), 64'(er[k]), 64'(m_err[k]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        en = '0; dir = '0; load = '0;
        for (int k = 0; k < 3; k++) lp[k] = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_state_a", 64'(state_a), 64'(3'b010));
        chk("rst_pos_b", 64'(pos_b), 64'(1));
        chk("rst_cnt_a", 64'(cnt_a), 64'(0));
        chk("rst_err_a", 64'(err_a), 64'(0));
        chk("rst_z1_a", 64'(z1_a), 64'(0));
        reset = 1'b1;
        chk_on = 1'b1;

        // T1: W=3 up from 010
        en[0] = 1'b1;
        cyc(); chk("t1_s1", 64'(state_a), 64'(3'b100)); chk("t1_w1", 64'(wrap_a), 64'(0));
        cyc(); chk("t1_s2", 64'(state_a), 64'(3'b001)); chk("t1_w2", 64'(wrap_a), 64'(1));
        cyc(); chk("t1_s3", 64'(state_a), 64'(3'b010)); chk("t1_w3", 64'(wrap_a), 64'(0));
        chk("t1_cnt", 64'(cnt_a), 64'(1));
        en[0] = 1'b0;

        // T2: W=5 S=2 down from 1
        en[1] = 1'b1; dir[1] = 1'b1;
        cyc(); chk("t2_p1", 64'(pos_b), 64'(4)); chk("t2_w1", 64'(wrap_b), 64'(1));
        cyc(); chk("t2_p2", 64'(pos_b), 64'(2)); chk("t2_w2", 64'(wrap_b), 64'(0));
        cyc(); chk("t2_p3", 64'(pos_b), 64'(0)); chk("t2_w3", 64'(wrap_b), 64'(0));
        chk("t2_z1", 64'(z1_b), 64'(0));
        // up from 0 by 2: 2,4, then wraps to 1
        dir[1] = 1'b0;
        cyc(); cyc(); cyc();
        chk("t2_up", 64'(state_b), 64'(5'b00010)); chk("t2_cnt", 64'(cnt_b), 64'(2));
        en[1] = 1'b0;

        // T3: load beats en
        load[0] = 1'b1; en[0] = 1'b1; lp[0] = 3'd2;
        cyc(); chk("t3_s", 64'(state_a), 64'(3'b100)); chk("t3_p", 64'(pos_a), 64'(2));
        chk("t3_w", 64'(wrap_a), 64'(0));
        load[0] = 1'b0; en[0] = 1'b0;

        // T4: illegal load position 3 on W=3
        load[0] = 1'b1; lp[0] = 3'd3;
        cyc(); chk("t4_s", 64'(state_a), 64'(3'b100)); chk("t4_err", 64'(err_a), 64'(1));
        load[0] = 1'b0;
        en[0] = 1'b1; dir[0] = 1'b1;
        cyc(); chk("t4_down", 64'(state_a), 64'(3'b010)); chk("t4_sticky", 64'(err_a), 64'(1));
        en[0] = 1'b0; dir[0] = 1'b0;

        // T5: W=2 wraps every other step, 2-bit counter saturates
        en[2] = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        chk("t5_cnt", 64'(cnt_c), 64'(3));
        en[2] = 1'b0;

        // T6: async reset pulse between edges while advancing
        en[0] = 1'b1;
        cyc();
        #1 reset = 1'b0;
        #1;
        chk("t6_state", 64'(state_a), 64'(3'b010));
        chk("t6_cnt", 64'(cnt_a), 64'(0));
        chk("t6_err", 64'(err_a), 64'(0));
        chk("t6_cnt_c", 64'(cnt_c), 64'(0));
        #1 reset = 1'b1;
        cyc(); chk("t6_resume", 64'(state_a), 64'(3'b100));
        en[0] = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
